// File: rtl/sim_ctrl.sv
// Bench-side run controller: staggered reset release, run watchdog, verdict, drain, finish.
// Optional heartbeat output enabled by defining SIM_CTRL_HEARTBEAT_EN.
module sim_ctrl #(
    parameter int MAX_CYCLES       = 10000,
    parameter int NUM_RST          = 2,
    parameter int RST_STAGGER      = 4,
    parameter int DRAIN_CYCLES     = 8,
    parameter int CNT_W            = 32,
    parameter int HEARTBEAT_PERIOD = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dut_done,
    input  logic               dut_fail,
    output logic [NUM_RST-1:0] rst_out,
    output logic               running,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
`ifdef SIM_CTRL_HEARTBEAT_EN
    output logic               heartbeat,
`endif
    output logic               finish
);

    localparam int HOLD_LEN = NUM_RST * RST_STAGGER;
    localparam int HW = $clog2(HOLD_LEN + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {HOLD, RUN, DRAIN, FIN} state_e;

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             to_q, to_d;
    logic             fin_q, fin_d;

`ifdef SIM_CTRL_HEARTBEAT_EN
    localparam int HBW = $clog2(HEARTBEAT_PERIOD + 1);
    // Tracks cycle_count modulo the heartbeat period
    logic [HBW-1:0] hb_q, hb_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            to_q        <= 1'b0;
            fin_q       <= 1'b0;
`ifdef SIM_CTRL_HEARTBEAT_EN
            hb_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            to_q        <= to_d;
            fin_q       <= fin_d;
`ifdef SIM_CTRL_HEARTBEAT_EN
            hb_q        <= hb_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        to_d        = to_q;
        fin_d       = 1'b0;
`ifdef SIM_CTRL_HEARTBEAT_EN
        hb_d        = hb_q;
`endif
        unique case (state_q)
            HOLD: begin
`ifdef SIM_CTRL_HEARTBEAT_EN
                hb_d = '0;
`endif
                if (hold_cnt_q == HW'(HOLD_LEN)) state_d = RUN;
                else hold_cnt_d = hold_cnt_q + HW'(1);
            end
            RUN: begin
                if (dut_fail) begin
                    state_d = DRAIN;
                    fail_d  = 1'b1;
                end else if (dut_done) begin
                    state_d = DRAIN;
                    pass_d  = 1'b1;
                end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = DRAIN;
                    to_d    = 1'b1;
                    fail_d  = 1'b1;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef SIM_CTRL_HEARTBEAT_EN
                    if (hb_q == HBW'(HEARTBEAT_PERIOD - 1)) hb_d = '0;
                    else hb_d = hb_q + HBW'(1);
`endif
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = FIN;
                    fin_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            FIN: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_RST; i++) begin
            rst_out[i] = (state_q == HOLD) &&
                         (int'(hold_cnt_q) < (i + 1) * RST_STAGGER);
        end
        running     = (state_q == RUN);
        cycle_count = cnt_q;
        pass        = pass_q;
        fail        = fail_q;
        timeout     = to_q;
        finish      = fin_q;
`ifdef SIM_CTRL_HEARTBEAT_EN
        heartbeat   = (state_q == RUN) && (hb_q == '0) && (cnt_q != '0);
`endif
    end

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: event-time reference model plus directed literal checks.
module tb_sim_ctrl;
    localparam int MAXC = 20;
    localparam int NR   = 2;
    localparam int STG  = 4;
    localparam int DRN  = 8;
    localparam int HBP  = 5;
    localparam int HLEN = NR * STG + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dut_done = 1'b0;
    logic          dut_fail = 1'b0;
    logic [NR-1:0] rst_out;
    logic          running;
    logic [31:0]   cycle_count;
    logic          pass, fail, timeout, finish;
`ifdef SIM_CTRL_HEARTBEAT_EN
    logic          heartbeat;
`endif

    int nchecks = 0;
    int nerr = 0;

    // Model: cycles since reset release, time and kind of verdict
    int m_t = 0;
    int m_vt = -1;
    int m_kind = 0;
    int m_vc = 0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    sim_ctrl #(
        .MAX_CYCLES(MAXC), .NUM_RST(NR), .RST_STAGGER(STG),
        .DRAIN_CYCLES(DRN), .CNT_W(32), .HEARTBEAT_PERIOD(HBP)
    ) dut (
        .clk(clk), .reset(reset), .dut_done(dut_done), .dut_fail(dut_fail),
        .rst_out(rst_out), .running(running), .cycle_count(cycle_count),
        .pass(pass), .fail(fail), .timeout(timeout),
`ifdef SIM_CTRL_HEARTBEAT_EN
        .heartbeat(heartbeat),
`endif
        .finish(finish)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, m_t, act, exp);
        end
    endtask

    task automatic model_update(bit r, bit d, bit f);
        int c;
        if (r) begin
            m_t = 0;
            m_vt = -1;
            m_valid = 1'b1;
            return;
        end
        if (m_t >= HLEN && m_vt < 0) begin
            c = m_t - HLEN;
            if (f) begin m_vt = m_t; m_kind = 1; m_vc = c; end
            else if (d) begin m_vt = m_t; m_kind = 0; m_vc = c; end
            else if (c == MAXC - 1) begin m_vt = m_t; m_kind = 2; m_vc = c; end
        end
        m_t++;
    endtask

    task automatic compare();
        logic [NR-1:0] er;
        int ec;
        bit erun, ep, ef, eto, efin;
        if (!m_valid) return;
        er = '0;
        ec = 0;
        erun = 0; ep = 0; ef = 0; eto = 0; efin = 0;
        if (m_t < HLEN) begin
            for (int i = 0; i < NR; i++) er[i] = (m_t < (i + 1) * STG);
        end else if (m_vt < 0) begin
            erun = 1;
            ec = m_t - HLEN;
        end else begin
            ec = m_vc;
            ep = (m_kind == 0);
            ef = (m_kind != 0);
            eto = (m_kind == 2);
            efin = (m_t == m_vt + DRN + 1);
        end
        chk("rst_out", 32'(rst_out), 32'(er));
        chk("running", 32'(running), 32'(erun));
        chk("cycle_count", cycle_count, ec);
        chk("pass", 32'(pass), 32'(ep));
        chk("fail", 32'(fail), 32'(ef));
        chk("timeout", 32'(timeout), 32'(eto));
        chk("finish", 32'(finish), 32'(efin));
`ifdef SIM_CTRL_HEARTBEAT_EN
        chk("heartbeat", 32'(heartbeat),
            32'(erun && ec != 0 && (ec % HBP) == 0));
`endif
    endtask

    task automatic step(bit r, bit d, bit f);
        reset = r;
        dut_done = d;
        dut_fail = f;
        @(posedge clk);
        model_update(r, d, f);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        // Reset release and staggered deassertion
        step(1, 0, 0);
        step(1, 0, 0);
        chk("lit_rst_reset", 32'(rst_out), 32'h3);
        idle(4);
        chk("lit_rst_t4", 32'(rst_out), 32'h2);
        idle(4);
        chk("lit_rst_t8", 32'(rst_out), 32'h0);
        chk("lit_run_t8", 32'(running), 32'h0);
        idle(1);
        chk("lit_run_t9", 32'(running), 32'h1);
        chk("lit_cnt_t9", cycle_count, 32'd0);
        // done at count 5
        idle(5);
        step(0, 1, 0);
        chk("lit_pass", 32'(pass), 32'h1);
        chk("lit_cnt5", cycle_count, 32'd5);
        chk("lit_running_drain", 32'(running), 32'h0);
        idle(7);
        chk("lit_fin_early", 32'(finish), 32'h0);
        idle(1);
        chk("lit_fin", 32'(finish), 32'h1);
        idle(1);
        chk("lit_fin_low", 32'(finish), 32'h0);
        chk("lit_pass_hold", 32'(pass), 32'h1);
        // timeout
        step(1, 0, 0);
        idle(29);
        chk("lit_timeout", 32'(timeout), 32'h1);
        chk("lit_to_fail", 32'(fail), 32'h1);
        chk("lit_to_cnt", cycle_count, 32'd19);
        idle(8);
        chk("lit_to_fin", 32'(finish), 32'h1);
        // fail beats done
        step(1, 0, 0);
        idle(12);
        step(0, 1, 1);
        chk("lit_fd_fail", 32'(fail), 32'h1);
        chk("lit_fd_pass", 32'(pass), 32'h0);
        chk("lit_fd_cnt", cycle_count, 32'd3);
        // done beats timeout
        step(1, 0, 0);
        idle(28);
        step(0, 1, 0);
        chk("lit_dt_pass", 32'(pass), 32'h1);
        chk("lit_dt_to", 32'(timeout), 32'h0);
        // reset mid-drain
        idle(3);
        step(1, 0, 0);
        chk("lit_abort_rst", 32'(rst_out), 32'h3);
        chk("lit_abort_pass", 32'(pass), 32'h0);
        chk("lit_abort_cnt", cycle_count, 32'd0);
        idle(9);
        chk("lit_abort_run", 32'(running), 32'h1);
        // randomized runs
        for (int k = 0; k < 3000; k++) begin
            bit r, d, f;
            r = ($urandom_range(0, 299) == 0);
            if (m_vt >= 0 && m_t > m_vt + DRN + 3) r = 1;
            d = ($urandom_range(0, 29) == 0);
            f = ($urandom_range(0, 59) == 0);
            step(r, d, f);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
